waveform_scroll_ctrl: RTL and testbench

WAVEFORM_SCROLL_CTRL -- requirements
Module: waveform_scroll_ctrl

---
 rtl/waveform_scroll_ctrl_pkg.sv | 23 ++
 rtl/waveform_scroll_ctrl_column_ram.sv | 41 ++++
 rtl/waveform_scroll_ctrl.sv | 173 +++++++++++++++++
 tb/tb_waveform_scroll_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_scroll_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// waveform_scroll_ctrl_pkg
//
// Shared definitions for the ECG waveform scroll controller:
//   - fill_state_t : buffer fill state, encoded EMPTY=0, FILLING=1, FULL=2.
//                    The encoding is visible on the controller's state port.
//   - DEFAULT_WIDTH: default number of display columns (circular buffer depth).
//   - SAMPLE_W     : width of one ECG sample and of one stored column.
//   - HCOUNT_W     : width of the pixel column counter from the video timing.
// -----------------------------------------------------------------------------
package waveform_scroll_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 1024;
  localparam int SAMPLE_W      = 8;
  localparam int HCOUNT_W      = 11;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } fill_state_t;

endpackage : waveform_scroll_ctrl_pkg

// File: rtl/waveform_scroll_ctrl_column_ram.sv
// -----------------------------------------------------------------------------
// column_ram
//
// Simple dual-port column store for the scrolling waveform: one synchronous
// write port and one registered read port on the same clock.
// A read of the address being written in the same cycle returns the old data.
//
// Ports:
//   clock   - the only clock
//   we      - write enable for wr_addr/wr_data
//   wr_addr - write address
//   wr_data - column value to store
//   rd_addr - read address, sampled every clock
//   rd_data - registered read data, one clock after rd_addr
// -----------------------------------------------------------------------------
module column_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; stale contents
  // are never shown because the controller masks them with out_valid.
  // Both the write and the read are non-blocking in one process, so a read of
  // the address being written samples the value from before this edge.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule : column_ram

// File: rtl/waveform_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// waveform_scroll_ctrl
//
// Scrolling ECG waveform buffer. Incoming samples are averaged in groups of
// 2^LOG_DECIM into columns. Each column is written into a circular buffer of
// WIDTH entries. At every frame start (vsync) the controller latches which
// buffer entry maps to screen column 0 and how many columns hold data. Every
// pixel column of that frame is then read through that fixed mapping, so the
// trace scrolls only between frames, never inside one.
//
// Ports:
//   clock        - system clock, the only clock
//   reset        - asynchronous, active-high reset
//   sample_valid - one-cycle strobe qualifying sample_in
//   sample_in    - unsigned 8-bit ECG sample
//   freeze       - level; while high, incoming samples are ignored
//   vsync        - one-cycle frame-start strobe; latches the frame snapshot
//   hcount       - current pixel column
//   signal_out   - column sample for hcount, two clocks later; 0 when invalid
//   out_valid    - signal_out holds written data (hcount < columns in frame)
//   state        - fill state: EMPTY=0, FILLING=1, FULL=2
// -----------------------------------------------------------------------------
module waveform_scroll_ctrl
  import waveform_scroll_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int LOG_DECIM = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                freeze,
  input  logic                vsync,
  input  logic [HCOUNT_W-1:0] hcount,
  output logic [SAMPLE_W-1:0] signal_out,
  output logic                out_valid,
  output logic [1:0]          state
);

  localparam int AW     = $clog2(WIDTH);
  localparam int FW     = AW + 1;            // fill count reaches WIDTH itself
  localparam int ACC_W  = SAMPLE_W + LOG_DECIM;
  localparam int CNT_W  = (LOG_DECIM > 0) ? LOG_DECIM : 1;
  localparam int CMP_W  = (FW > HCOUNT_W) ? FW : HCOUNT_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG_DECIM) - 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(WIDTH);

  // ---------------------------------------------------------------------------
  // Decimator
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    dec_cnt;
  logic                accept;
  logic                col_we;
  logic [ACC_W-1:0]    acc_sum;
  logic [SAMPLE_W-1:0] col_data;

  assign accept   = sample_valid && !freeze;
  assign acc_sum  = acc + ACC_W'(sample_in);
  // The last sample of a group is folded in combinationally, so the column is
  // written on the same edge that accepts that sample.
  assign col_we   = accept && (dec_cnt == CNT_LAST);
  assign col_data = SAMPLE_W'(acc_sum >> LOG_DECIM);

  // NOTE: all state registers use non-blocking assignments so every block sees
  // the pre-edge values of the others (vsync snapshot vs. column write).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      dec_cnt <= '0;
    end else if (accept) begin
      if (dec_cnt == CNT_LAST) begin
        acc     <= '0;
        dec_cnt <= '0;
      end else begin
        acc     <= acc_sum;
        dec_cnt <= dec_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointer, fill count and fill state machine
  // ---------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr;
  logic [FW-1:0] fill_cnt;
  fill_state_t   fill_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      fill_state <= EMPTY;
    end else if (col_we) begin
      // WIDTH is a power of two, so the natural wrap is the modulo.
      wr_ptr <= wr_ptr + 1'b1;
      if (fill_cnt != FILL_MAX) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
      case (fill_state)
        EMPTY:   fill_state <= (fill_cnt == FILL_MAX - 1'b1) ? FULL : FILLING;
        FILLING: fill_state <= (fill_cnt == FILL_MAX - 1'b1) ? FULL : FILLING;
        FULL:    fill_state <= FULL;
        default: fill_state <= EMPTY;
      endcase
    end
  end

  assign state = fill_state;

  // ---------------------------------------------------------------------------
  // Frame snapshot
  // ---------------------------------------------------------------------------
  // Until the buffer has wrapped, the oldest column sits at address 0. Once
  // full, the oldest column is the one about to be overwritten, at wr_ptr.
  // A write on the same edge as vsync is not yet visible here, so the frame
  // uses the pre-write pointer and count.
  logic [AW-1:0] frame_base;
  logic [FW-1:0] frame_fill;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_base <= '0;
      frame_fill <= '0;
    end else if (vsync) begin
      frame_base <= (fill_state == FULL) ? wr_ptr : '0;
      frame_fill <= fill_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: address register, then the RAM's registered read
  // ---------------------------------------------------------------------------
  logic [AW-1:0]       rd_addr;
  logic                in_frame;
  logic                hit_s1;
  logic                hit_s2;
  logic [SAMPLE_W-1:0] ram_q;

  // The full hcount is compared, so columns at or beyond WIDTH are never valid.
  assign in_frame = (CMP_W'(hcount) < CMP_W'(frame_fill));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      hit_s1  <= 1'b0;
      hit_s2  <= 1'b0;
    end else begin
      rd_addr <= frame_base + hcount[AW-1:0];
      hit_s1  <= in_frame;
      hit_s2  <= hit_s1;
    end
  end

  column_ram #(
    .ADDR_W (AW),
    .DATA_W (SAMPLE_W)
  ) u_column_ram (
    .clock   (clock),
    .we      (col_we),
    .wr_addr (wr_ptr),
    .wr_data (col_data),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Unwritten or stale RAM words never reach the renderer.
  assign signal_out = hit_s2 ? ram_q : '0;
  assign out_valid  = hit_s2;

endmodule : waveform_scroll_ctrl

// File: tb/tb_waveform_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_waveform_scroll_ctrl
//
// Self-checking bench for waveform_scroll_ctrl with default parameters.
// Inputs change 1 ns after the rising clock edge and outputs are sampled there.
// The reference model keeps the list of columns written so far and the samples
// of the group still being collected. Expected outputs are derived from those.
// -----------------------------------------------------------------------------
module tb_waveform_scroll_ctrl;
  import waveform_scroll_ctrl_pkg::*;

  localparam int W     = 1024;
  localparam int LOG_D = 2;
  localparam int DECIM = 1 << LOG_D;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  sample_in = '0;
  logic        freeze = 1'b0;
  logic        vsync = 1'b0;
  logic [10:0] hcount = '0;
  logic [7:0]  signal_out;
  logic        out_valid;
  logic [1:0]  state;

  always #5 clock = ~clock;

  waveform_scroll_ctrl #(
    .WIDTH     (W),
    .LOG_DECIM (LOG_D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .freeze       (freeze),
    .vsync        (vsync),
    .hcount       (hcount),
    .signal_out   (signal_out),
    .out_valid    (out_valid),
    .state        (state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_cols;          // total columns written since reset
  int m_mem[W];        // buffer contents (survive reset, like the RAM)
  int m_part[$];       // samples of the group still being collected
  int m_base;          // buffer index shown at screen column 0
  int m_fill;          // columns shown in the current frame
  bit m_freeze;

  function automatic void model_reset();
    m_cols = 0;
    m_part.delete();
    m_base = 0;
    m_fill = 0;
  endfunction

  function automatic void model_sample(int v);
    int sum;
    if (m_freeze) return;
    m_part.push_back(v);
    if (m_part.size() == DECIM) begin
      sum = 0;
      foreach (m_part[i]) sum += m_part[i];
      m_mem[m_cols % W] = sum / DECIM;
      m_cols++;
      m_part.delete();
    end
  endfunction

  function automatic void model_vsync();
    m_base = (m_cols >= W) ? (m_cols % W) : 0;
    m_fill = (m_cols >= W) ? W : m_cols;
  endfunction

  function automatic int exp_state();
    if (m_cols == 0) return 0;
    if (m_cols < W)  return 1;
    return 2;
  endfunction

  function automatic int exp_valid(int h);
    return (h < m_fill) ? 1 : 0;
  endfunction

  function automatic int exp_data(int h);
    return (h < m_fill) ? m_mem[(m_base + h) % W] : 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and driving
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    check("async_reset_state", state, 0);
    check("async_reset_valid", out_valid, 0);
    check("async_reset_data", signal_out, 0);
    @(posedge clock);
    #1;
    check("reset_hold_state", state, 0);
    check("reset_hold_valid", out_valid, 0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic push(input int v, input bit with_vsync = 1'b0);
    sample_in    = 8'(v);
    sample_valid = 1'b1;
    vsync        = with_vsync;
    if (with_vsync) model_vsync();   // snapshot takes pre-write values
    model_sample(v);
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    vsync        = 1'b0;
  endtask

  task automatic push_col(input int v);
    for (int i = 0; i < DECIM; i++) push(v);
  endtask

  task automatic do_vsync();
    vsync = 1'b1;
    model_vsync();
    @(posedge clock);
    #1;
    vsync = 1'b0;
  endtask

  // Present one hcount and return the answer exactly two clocks later.
  task automatic read_check(input string tag, input int h,
                            output logic [7:0] d, output logic v);
    hcount = 11'(h);
    repeat (2) @(posedge clock);
    #1;
    d = signal_out;
    v = out_valid;
    check({tag, "_data"}, d, exp_data(h));
    check({tag, "_valid"}, v, exp_valid(h));
    check({tag, "_state"}, state, exp_state());
  endtask

  // Back-to-back hcount values; each answer is compared two clocks later.
  task automatic sweep(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi + 1; i++) begin
      if (i <= hi) hcount = 11'(i);
      @(posedge clock);
      #1;
      if (i > lo) begin
        check({tag, "_data"}, signal_out, exp_data(i - 1));
        check({tag, "_valid"}, out_valid, exp_valid(i - 1));
        check({tag, "_state"}, state, exp_state());
      end
    end
  endtask

  task automatic rand_phase(input string tag, input int n);
    logic [7:0] d;
    logic       v;
    int         r;
    int         h;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        m_freeze = !m_freeze;
        freeze   = m_freeze;
      end else if (r < 60) begin
        push($urandom_range(0, 255), ($urandom_range(0, 9) == 0));
      end else if (r < 70) begin
        do_vsync();
      end else begin
        case ($urandom_range(0, 2))
          0:       h = m_fill;
          1:       h = (m_fill > 0) ? m_fill - 1 : 0;
          default: h = $urandom_range(0, 2047);
        endcase
        if (h > 2047) h = 2047;
        read_check(tag, h, d, v);
      end
    end
    m_freeze = 1'b0;
    freeze   = 1'b0;
  endtask

  typedef struct {
    int s[DECIM];
    int exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] d;
    logic       v;
    int         old_val;

    tbl[0] = '{s: '{10, 20, 30, 40},     exp: 25};
    tbl[1] = '{s: '{255, 255, 255, 255}, exp: 255};
    tbl[2] = '{s: '{0, 0, 0, 3},         exp: 0};
    tbl[3] = '{s: '{1, 2, 3, 4},         exp: 2};
    tbl[4] = '{s: '{255, 255, 255, 254}, exp: 254};

    m_freeze = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 0;
    model_reset();
    #1;
    apply_reset();

    // Empty buffer: every column blank.
    sweep("empty_sweep", 0, W - 1);
    check("empty_state", state, 0);

    // Decimation vectors: one column per row, shown after the next vsync.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < DECIM; k++) push(tbl[r].s[k]);
      do_vsync();
      read_check("tbl_col", r, d, v);
      check("tbl_value", d, tbl[r].exp);
      check("tbl_value_valid", v, 1);
      read_check("tbl_next", r + 1, d, v);
      check("tbl_next_invalid", v, 0);
      check("tbl_state", state, 1);
    end

    // Freeze holds a partial group across many strobes.
    push(11);
    push(13);
    m_freeze = 1'b1;
    freeze   = 1'b1;
    for (int k = 0; k < 400; k++) push($urandom_range(0, 255));
    do_vsync();
    read_check("frz_last", 4, d, v);
    check("frz_last_valid", v, 1);
    read_check("frz_edge", 5, d, v);
    check("frz_edge_invalid", v, 0);
    m_freeze = 1'b0;
    freeze   = 1'b0;
    push(15);
    push(17);
    do_vsync();
    read_check("frz_col", 5, d, v);
    check("frz_col_value", d, 14);
    read_check("frz_col_next", 6, d, v);
    check("frz_col_next_invalid", v, 0);

    // A write inside a frame does not change what that frame shows.
    push_col(99);
    read_check("mid_new", 6, d, v);
    check("mid_new_hidden", v, 0);
    read_check("mid_old", 5, d, v);
    check("mid_old_value", d, 14);
    do_vsync();
    read_check("mid_after", 6, d, v);
    check("mid_after_value", d, 99);

    rand_phase("rand_fill", 300);

    // Reset in the middle of a group discards the partial samples.
    apply_reset();
    push(250);
    push(250);
    apply_reset();
    push_col(100);
    do_vsync();
    read_check("rst_col", 0, d, v);
    check("rst_col_value", d, 100);
    read_check("rst_col_next", 1, d, v);
    check("rst_col_next_invalid", v, 0);

    // Wrap: 1026 columns, value k mod 256.
    apply_reset();
    for (int k = 0; k < W + 2; k++) push_col(k % 256);
    do_vsync();
    check("wrap_state", state, 2);
    read_check("wrap_h0", 0, d, v);
    check("wrap_h0_value", d, 2);
    read_check("wrap_h1023", W - 1, d, v);
    check("wrap_h1023_value", d, 1);
    read_check("wrap_h1024", W, d, v);
    check("wrap_h1024_invalid", v, 0);
    read_check("wrap_h2047", 2047, d, v);
    check("wrap_h2047_invalid", v, 0);
    read_check("wrap_h512", 512, d, v);

    // Column write coincident with vsync while wr_ptr = 5.
    push_col(200);
    push_col(201);
    push_col(202);
    for (int k = 0; k < DECIM - 1; k++) push(77);
    push(77, 1'b1);
    read_check("coinc_h0", 0, d, v);
    check("coinc_h0_value", d, 77);
    read_check("coinc_h1023", W - 1, d, v);
    check("coinc_h1023_value", d, 202);

    // Read-during-write of the same address returns the old word.
    hcount = 11'd1;                  // base 5 + 1 = address 6 = next write
    for (int k = 0; k < DECIM - 1; k++) push(88);
    old_val      = m_mem[6];
    sample_in    = 8'd88;
    sample_valid = 1'b1;
    model_sample(88);
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
    check("rdw_old", signal_out, old_val);
    check("rdw_old_const", signal_out, 6);
    @(posedge clock);
    #1;
    check("rdw_new", signal_out, 88);

    rand_phase("rand_full", 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_waveform_scroll_ctrl
